// File: rtl/pipe_stage_hs_pkg.sv
// rtl/pipe_stage_hs_pkg.sv - shared widths, exception bit indices, payload type and stage state encoding
package pipe_stage_hs_pkg;

  localparam int XLEN          = 32;
  localparam int PC_WIDTH      = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int EXCP_W        = 6;

  // Exception flag bit positions inside the per-stage exception vector
  localparam int EXCP_MISALIGN = 0;
  localparam int EXCP_BUS_ERR  = 1;
  localparam int EXCP_ILLEGAL  = 2;
  localparam int EXCP_ECALL    = 3;
  localparam int EXCP_EBREAK   = 4;
  localparam int EXCP_MRET     = 5;

  // Example boundary payload; stages pack their own struct and pass $bits() as DW
  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    logic [REG_IDX_WIDTH-1:0] rd_idx;
    logic                     rd_en;
    logic [XLEN-1:0]          wdata;
  } wb_payload_t;

  localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

  // Stage occupancy encoded as {skid_v, main_v}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  // Decode the two slot valids into the stage state; a lone skid entry is
  // unreachable and is treated as FULL so up_ready stays low.
  function automatic stage_state_e state_of(input logic main_v, input logic skid_v);
    stage_state_e st;
    case ({skid_v, main_v})
      2'b00:   st = ST_EMPTY;
      2'b01:   st = ST_ONE;
      default: st = ST_FULL;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// rtl/pipe_stage_hs_if.sv - upstream/downstream handshake bundle of one pipeline boundary
interface pipe_stage_hs_if
  import pipe_stage_hs_pkg::*;
#(
  parameter int DW = 64,
  parameter int EW = EXCP_W
);

  logic          flush_i;
  logic          up_valid_i;
  logic          up_ready_o;
  logic [DW-1:0] up_data_i;
  logic [EW-1:0] up_excp_i;
  logic          dn_valid_o;
  logic          dn_ready_i;
  logic [DW-1:0] dn_data_o;
  logic [EW-1:0] dn_excp_o;
  logic          dn_excp_any_o;
  logic [1:0]    occ_o;

  // Stage side
  modport slave (
    input  flush_i, up_valid_i, up_data_i, up_excp_i, dn_ready_i,
    output up_ready_o, dn_valid_o, dn_data_o, dn_excp_o, dn_excp_any_o, occ_o
  );

  // Core/environment side driving the stage
  modport master (
    output flush_i, up_valid_i, up_data_i, up_excp_i, dn_ready_i,
    input  up_ready_o, dn_valid_o, dn_data_o, dn_excp_o, dn_excp_any_o, occ_o
  );

endinterface

// File: rtl/pipe_stage_hs_slot.sv
// rtl/pipe_stage_hs_slot.sv - one pipeline entry: valid flop plus payload/exception flop
module pipe_stage_hs_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int DW          = 64,
  parameter int EW          = EXCP_W,
  parameter bit CLR_ON_KILL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kill_i,
  input  logic          load_i,
  input  logic          drop_i,
  input  logic [DW-1:0] data_i,
  input  logic [EW-1:0] excp_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [EW-1:0] excp_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [EW-1:0] excp_q, excp_d;

  // Next entry contents: kill beats load beats drop; payload moves only on load
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    excp_d  = excp_q;
    if (kill_i) begin
      valid_d = 1'b0;
      if (CLR_ON_KILL) begin
        data_d = '0;
        excp_d = '0;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      excp_d  = excp_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      excp_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      excp_q  <= excp_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign excp_o  = excp_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - pipeline-stage register with valid/ready handshake, flush and optional skid entry
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int DW          = 64,
  parameter int EW          = EXCP_W,
  parameter bit SKID        = 1'b1,
  parameter bit CLR_ON_KILL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_stage_hs_if.slave  bus
);

  logic          main_v, skid_v;
  logic [DW-1:0] main_data, skid_data, main_src_data;
  logic [EW-1:0] main_excp, skid_excp, main_src_excp;
  logic          up_ready, up_xfer, dn_xfer;
  logic          main_load, main_drop, main_from_skid;
  logic          skid_load, skid_drop;
  stage_state_e  st_cur;

  // With a skid entry ready comes straight from a flop; without one the
  // register can refill in the same cycle it drains.
  assign up_ready = SKID ? ~skid_v : (~main_v | bus.dn_ready_i);
  assign up_xfer  = bus.up_valid_i & up_ready;
  assign dn_xfer  = main_v & bus.dn_ready_i;

  // Slot load/drop controls from the current occupancy and both handshakes
  always_comb begin
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    st_cur         = state_of(main_v, skid_v);
    case (st_cur)
      ST_EMPTY: main_load = up_xfer;
      ST_ONE: begin
        if (up_xfer && dn_xfer) begin
          main_load = 1'b1;
        end else if (up_xfer) begin
          skid_load = 1'b1;
        end else if (dn_xfer) begin
          main_drop = 1'b1;
        end
      end
      ST_FULL: begin
        if (dn_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The head is refilled from the older skid entry before any new beat
  assign main_src_data = main_from_skid ? skid_data : bus.up_data_i;
  assign main_src_excp = main_from_skid ? skid_excp : bus.up_excp_i;

  pipe_stage_hs_slot #(
    .DW          (DW),
    .EW          (EW),
    .CLR_ON_KILL (CLR_ON_KILL)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .kill_i  (bus.flush_i),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .data_i  (main_src_data),
    .excp_i  (main_src_excp),
    .valid_o (main_v),
    .data_o  (main_data),
    .excp_o  (main_excp)
  );

  if (SKID) begin : g_skid
    pipe_stage_hs_slot #(
      .DW          (DW),
      .EW          (EW),
      .CLR_ON_KILL (CLR_ON_KILL)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .kill_i  (bus.flush_i),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .data_i  (bus.up_data_i),
      .excp_i  (bus.up_excp_i),
      .valid_o (skid_v),
      .data_o  (skid_data),
      .excp_o  (skid_excp)
    );
  end else begin : g_no_skid
    assign skid_v    = 1'b0;
    assign skid_data = '0;
    assign skid_excp = '0;
  end

  assign bus.up_ready_o    = up_ready;
  assign bus.dn_valid_o    = main_v;
  assign bus.dn_data_o     = main_data;
  assign bus.dn_excp_o     = main_excp;
  assign bus.dn_excp_any_o = main_v & (|main_excp);
  assign bus.occ_o         = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - directed vector bench for pipe_stage_hs (skid and no-skid builds)
module tb_pipe_stage_hs;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_stage_hs_if #(.DW(64), .EW(6)) if1 ();
  pipe_stage_hs_if #(.DW(64), .EW(6)) if0 ();

  pipe_stage_hs #(.DW(64), .EW(6), .SKID(1'b1), .CLR_ON_KILL(1'b1)) u_dut_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  pipe_stage_hs #(.DW(64), .EW(6), .SKID(1'b0), .CLR_ON_KILL(1'b1)) u_dut_noskid (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  typedef struct {
    logic        fl;
    logic        uv;
    logic [63:0] ud;
    logic [5:0]  ue;
    logic        dr;
    logic        ev;
    logic [63:0] ed;
    logic [5:0]  ee;
    logic        ea;
    logic [1:0]  eo;
    logic        er;
    logic        cd;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic fl, input logic uv, input logic [63:0] ud,
                              input logic [5:0] ue, input logic dr, input logic ev,
                              input logic [63:0] ed, input logic [5:0] ee, input logic ea,
                              input logic [1:0] eo, input logic er, input logic cd);
    vec_t v;
    v.fl = fl; v.uv = uv; v.ud = ud; v.ue = ue; v.dr = dr;
    v.ev = ev; v.ed = ed; v.ee = ee; v.ea = ea; v.eo = eo; v.er = er; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if1.flush_i = 0; if1.up_valid_i = 0; if1.up_data_i = '0; if1.up_excp_i = '0; if1.dn_ready_i = 0;
    if0.flush_i = 0; if0.up_valid_i = 0; if0.up_data_i = '0; if0.up_excp_i = '0; if0.dn_ready_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Expected columns describe the stage before the clock edge that follows the inputs.
    //           fl uv ud     ue        dr   ev ed     ee ea eo er cd
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 1,     0,        1,   0, 0,     0, 0, 0, 1, 1));
    for (int k = 2; k <= 8; k++)
      vq.push_back(mk(0, 1, 64'(k), 0,     1,   1, 64'(k - 1), 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   1, 8,     0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 'hA,   0,        0,   0, 0,     0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 'hB,   0,        0,   1, 'hA,   0, 0, 1, 1, 1));
    vq.push_back(mk(0, 1, 'hC,   0,        0,   1, 'hA,   0, 0, 2, 0, 1));
    vq.push_back(mk(0, 0, 0,     0,        0,   1, 'hA,   0, 0, 2, 0, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   1, 'hA,   0, 0, 2, 0, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   1, 'hB,   0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 1,     0,        0,   0, 0,     0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 2,     0,        0,   1, 1,     0, 0, 1, 1, 1));
    vq.push_back(mk(1, 1, 'hC,   0,        0,   1, 1,     0, 0, 2, 0, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 5,     0,        0,   0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 'hC,   0,        0,   1, 5,     0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 'h33,  6'b000100, 0,  0, 0,     0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        0,   1, 'h33,  4, 1, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   1, 'h33,  4, 1, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,     0,        1,   0, 0,     0, 0, 0, 1, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      if1.flush_i    = vq[i].fl;
      if1.up_valid_i = vq[i].uv;
      if1.up_data_i  = vq[i].ud;
      if1.up_excp_i  = vq[i].ue;
      if1.dn_ready_i = vq[i].dr;
      #1;
      chk($sformatf("v%0d dn_valid", i), 64'(if1.dn_valid_o), 64'(vq[i].ev));
      chk($sformatf("v%0d occ", i), 64'(if1.occ_o), 64'(vq[i].eo));
      chk($sformatf("v%0d up_ready", i), 64'(if1.up_ready_o), 64'(vq[i].er));
      chk($sformatf("v%0d excp_any", i), 64'(if1.dn_excp_any_o), 64'(vq[i].ea));
      if (vq[i].cd) begin
        chk($sformatf("v%0d dn_data", i), if1.dn_data_o, vq[i].ed);
        chk($sformatf("v%0d dn_excp", i), 64'(if1.dn_excp_o), 64'(vq[i].ee));
      end
    end

    // Asynchronous reset while the skid build holds two entries
    @(negedge clk);
    if1.flush_i = 0; if1.up_valid_i = 1; if1.up_data_i = 'hD; if1.up_excp_i = '0; if1.dn_ready_i = 0;
    @(negedge clk);
    if1.up_data_i = 'hE;
    @(negedge clk);
    if1.up_valid_i = 0;
    #1;
    chk("rst pre occ", 64'(if1.occ_o), 64'd2);
    chk("rst pre up_ready", 64'(if1.up_ready_o), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async dn_valid", 64'(if1.dn_valid_o), 64'd0);
    chk("rst async occ", 64'(if1.occ_o), 64'd0);
    chk("rst async up_ready", 64'(if1.up_ready_o), 64'd1);
    chk("rst async dn_data", if1.dn_data_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if1.dn_ready_i = 1;
    #1;
    chk("rst release dn_valid", 64'(if1.dn_valid_o), 64'd0);
    chk("rst release up_ready", 64'(if1.up_ready_o), 64'd1);

    // No-skid build: combinational ready follows dn_ready_i in the same cycle
    @(negedge clk);
    if0.up_valid_i = 1; if0.up_data_i = 'h11; if0.dn_ready_i = 0;
    #1;
    chk("ns empty up_ready", 64'(if0.up_ready_o), 64'd1);
    chk("ns empty dn_valid", 64'(if0.dn_valid_o), 64'd0);
    @(negedge clk);
    if0.up_data_i = 'h22;
    #1;
    chk("ns stall up_ready", 64'(if0.up_ready_o), 64'd0);
    chk("ns stall dn_data", if0.dn_data_o, 64'h11);
    chk("ns stall occ", 64'(if0.occ_o), 64'd1);
    if0.dn_ready_i = 1;
    #1;
    chk("ns release up_ready", 64'(if0.up_ready_o), 64'd1);
    @(negedge clk);
    if0.up_valid_i = 0; if0.dn_ready_i = 0;
    #1;
    chk("ns refill dn_valid", 64'(if0.dn_valid_o), 64'd1);
    chk("ns refill dn_data", if0.dn_data_o, 64'h22);
    chk("ns refill occ", 64'(if0.occ_o), 64'd1);
    if0.dn_ready_i = 1;
    @(negedge clk);
    #1;
    chk("ns drain dn_valid", 64'(if0.dn_valid_o), 64'd0);
    chk("ns drain occ", 64'(if0.occ_o), 64'd0);
    chk("ns drain up_ready", 64'(if0.up_ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
